ldpc_dec_sched: RTL and testbench

Frame scheduler in front of the single 256-bit bit-flipping LDPC decoder core. It arbitrates round-robin between two codeword requesters and issues one frame at a time to the decoder over its work/free/valid handshake. It captures the decoded word and returns it with a source tag through a valid/ready result port. It sits between the ingress framers and the decoder core; the core's own iteration control is untouched.

---
 rtl/ldpc_dec_sched_pkg.sv | 7 +
 rtl/ldpc_dec_sched_if.sv | 23 ++
 rtl/ldpc_dec_sched_arb.sv | 15 +
 rtl/ldpc_dec_sched.sv | 92 +++++++++
 tb/tb_ldpc_dec_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_dec_sched_pkg.sv
// ldpc_pkg: codeword width, scheduler state encoding and source-id type shared
// with the decoder-side blocks.
package ldpc_pkg;
    localparam int N = 256;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} sched_state_t;
    typedef logic src_t;
endpackage

// File: rtl/ldpc_dec_sched_if.sv
// ldpc_dec_sched_if: decoder work/free/valid handshake plus the valid/ready
// result port; master is the scheduler side.
interface ldpc_dec_sched_if;
    import ldpc_pkg::*;
    logic         dec_work;
    logic [N-1:0] dec_tx;
    logic         dec_free;
    logic         dec_valid;
    logic [N-1:0] dec_deout;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    src_t         res_src;
    logic         res_err;
    modport master (
        output dec_work, dec_tx, res_valid, res_data, res_src, res_err,
        input  dec_free, dec_valid, dec_deout, res_ready
    );
    modport slave (
        input  dec_work, dec_tx, res_valid, res_data, res_src, res_err,
        output dec_free, dec_valid, dec_deout, res_ready
    );
endinterface

// File: rtl/ldpc_dec_sched_arb.sv
// rr_arb2: two-request round-robin arbiter; the last-grant pointer moves only
// when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;
    always_comb gnt = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or negedge rst)
        if (!rst) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/ldpc_dec_sched.sv
// ldpc_dec_sched: round-robin frame scheduler in front of the LDPC decoder core.
// Define LDPC_SCHED_TIMEOUT_EN to add the decoder-valid watchdog with raw fallback.
module ldpc_dec_sched
    import ldpc_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [N-1:0]            din0,
    input  logic [N-1:0]            din1,
    output logic                    ack0,
    output logic                    ack1,
    ldpc_dec_sched_if.master        dif,
    output logic                    busy,
    output logic [CW-1:0]           frame_cnt
);
    sched_state_t state;
    logic [N-1:0] fbuf;
    src_t         src;
    logic [1:0]   gnt;
    logic         tmo;

    if (TIMEOUT < 2 || TIMEOUT > 2 ** CW) begin : g_bad_timeout
        $error("ldpc_dec_sched: TIMEOUT must fit the CW-bit counter");
    end

    // grants are masked while reset is held so no ack leaks out of reset
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == IDLE && rst),
        .req ({req1, req0}),
        .gnt (gnt)
    );

    assign {ack1, ack0}  = gnt;
    assign dif.dec_work  = state == ISSUE && dif.dec_free;
    assign dif.dec_tx    = fbuf;
    assign dif.res_valid = state == HOLD;
    assign dif.res_src   = src;
    assign busy          = state != IDLE;

`ifdef LDPC_SCHED_TIMEOUT_EN
    logic [CW-1:0] tcnt;
    logic          err;
    assign tmo         = tcnt == CW'(TIMEOUT - 1);
    assign dif.res_err = err;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= state == WAIT ? tcnt + CW'(1) : '0;
            if (state == WAIT && (dif.dec_valid || tmo)) err <= !dif.dec_valid;
        end
`else
    assign tmo         = 1'b0;
    assign dif.res_err = 1'b0;
`endif

    // a decoder strobe in the same cycle as the watchdog expiry takes priority
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state        <= IDLE;
            fbuf         <= '0;
            src          <= 1'b0;
            dif.res_data <= '0;
            frame_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    fbuf  <= gnt[1] ? din1 : din0;
                    src   <= gnt[1];
                    state <= ISSUE;
                end
                ISSUE: if (dif.dec_free) state <= WAIT;
                WAIT: if (dif.dec_valid || tmo) begin
                    dif.res_data <= dif.dec_valid ? dif.dec_deout : fbuf;
                    state        <= HOLD;
                end
                HOLD: if (dif.res_ready) begin
                    frame_cnt <= frame_cnt + CW'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ldpc_dec_sched.sv
// tb_ldpc_dec_sched: randomized bench with a transaction-level scoreboard for the
// frame scheduler; the watchdog scenario is built only with LDPC_SCHED_TIMEOUT_EN.
module tb_ldpc_dec_sched;
    import ldpc_pkg::*;
`ifdef LDPC_SCHED_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, req1, ack0, ack1, busy;
    logic [N-1:0]  din0, din1;
    logic [CW-1:0] frame_cnt;
    logic [1:0]    rq_m = 2'b00;
    logic [N-1:0]  din_m [2];

    assign req0 = rq_m[0];
    assign req1 = rq_m[1];
    assign din0 = din_m[0];
    assign din1 = din_m[1];

    ldpc_dec_sched_if dif ();

    ldpc_dec_sched #(.TIMEOUT(TMO), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .din0      (din0),
        .din1      (din1),
        .ack0      (ack0),
        .ack1      (ack1),
        .dif       (dif.master),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // scoreboard: one frame in flight, described by what the spec promises
    logic          inflight, issued, win, res_exp, exp_err, last, src, real_v, dec_busy;
    logic [N-1:0]  fr, exp_data, dec_frame;
    logic [CW-1:0] cnt;
    int            w, dec_lat, stall, ready_hold, n_work, n_ack;
    logic [7:0]    hist;
    int            left [2], gap [2];
    // stimulus knobs
    int   fix_lat = 0, gap_max = 0;
    logic ones_din = 0, stall_on_grant = 0, hold_ready = 0, rnd_ready = 0, rnd_stall = 0;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        inflight = 0; issued = 0; win = 0; res_exp = 0; last = 1; src = 0;
        cnt = '0; dec_busy = 0; dec_lat = 0; stall = 0; ready_hold = 0; w = 0;
    endtask

    task automatic check_reset();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_dec_work", dif.dec_work, 0);
        check("rst_dec_tx", dif.dec_tx, 0);
        check("rst_res_valid", dif.res_valid, 0);
        check("rst_res_data", dif.res_data, 0);
        check("rst_res_src", dif.res_src, 0);
        check("rst_res_err", dif.res_err, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
    endtask

    // call at posedge+1: async reset must take effect without a clock edge
    task automatic do_reset();
        rst = 0;
        #1 check_reset();
        @(negedge clk);
        check_reset();
        model_reset();
        dif.dec_valid = 0;
        dif.dec_free  = 1;
        real_v        = 0;
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic cycle();
        logic [1:0] rq, acked;
        logic       g, wn;
        @(negedge clk);
        rq    = {req1, req0};
        g     = !inflight && (|rq);
        wn    = (&rq) ? !last : rq[1];
        acked = 2'b00;
        check("busy", busy, inflight);
        check("dec_work", dif.dec_work, inflight && !issued && dif.dec_free);
        check("res_valid", dif.res_valid, res_exp);
        check("frame_cnt", frame_cnt, cnt);
        check("ack0", ack0, g && !wn);
        check("ack1", ack1, g && wn);
        if (res_exp) begin
            check("res_data", dif.res_data, exp_data);
            check("res_src", dif.res_src, src);
            check("res_err", dif.res_err, exp_err);
        end
        if (dif.dec_work) n_work++;
        if (ack0 || ack1) begin
            n_ack++;
            hist = {hist[6:0], ack1};
        end
        if (res_exp && dif.res_ready) begin
            cnt++;
            res_exp = 0; inflight = 0; issued = 0;
        end
        if (win) begin
            w++;
            if (dif.dec_valid && real_v) begin
                res_exp = 1; exp_data = ~fr; exp_err = 0; win = 0;
            end
`ifdef LDPC_SCHED_TIMEOUT_EN
            else if (w == TMO) begin
                res_exp = 1; exp_data = fr; exp_err = 1; win = 0;
            end
`endif
            if (!win && hold_ready) ready_hold = 50;
        end
        if (inflight && !issued && dif.dec_free) begin
            check("dec_tx", dif.dec_tx, fr);
            issued = 1; win = 1; w = 0;
            dec_busy = 1; dec_frame = dif.dec_tx;
            dec_lat = fix_lat != 0 ? fix_lat : $urandom_range(40, 1);
        end
        if (g) begin
            inflight = 1; src = wn; last = wn; fr = din_m[wn];
            acked[wn] = 1'b1;
            if (stall_on_grant) stall = 21;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acked[i]) begin
                left[i]--;
                rq_m[i] = 1'b0;
                gap[i]  = $urandom_range(gap_max, 0);
            end
            if (!rq_m[i] && left[i] > 0) begin
                if (gap[i] > 0) gap[i]--;
                else begin
                    rq_m[i]  = 1'b1;
                    din_m[i] = ones_din ? '1 : rnd();
                end
            end
        end
        dif.dec_valid = 0;
        real_v        = 0;
        if (dec_busy) begin
            dec_lat--;
            if (dec_lat == 0) begin
                dec_busy = 0; dif.dec_valid = 1; real_v = 1; dif.dec_deout = ~dec_frame;
            end
        end else if (!win && $urandom_range(7, 0) == 0) begin
            dif.dec_valid = 1; dif.dec_deout = rnd();
        end
        if (stall > 0) stall--;
        else if (rnd_stall && $urandom_range(15, 0) == 0) stall = $urandom_range(20, 1);
        dif.dec_free = !dec_busy && stall == 0;
        if (ready_hold > 0) begin
            ready_hold--;
            dif.res_ready = 0;
        end else dif.res_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    endtask

    task automatic run_until_cnt(input string tag, input logic [CW-1:0] target, input int lim);
        for (int k = 0; k < lim && cnt != target; k++) cycle();
        check(tag, cnt == target, 1);
    endtask

    initial begin
        din_m[0] = '0; din_m[1] = '0;
        dif.dec_free = 1; dif.dec_valid = 0; dif.dec_deout = '0; dif.res_ready = 1;
        real_v = 0; hist = '0; n_work = 0; n_ack = 0;
        left = '{0, 0}; gap = '{0, 0};
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset();
        do_reset();

        // single all-ones frame from requester 0, decoder answers after 40 cycles
        ones_din = 1; fix_lat = 40; left = '{1, 0};
        run_until_cnt("p1_done", 1, 300);
        check("p1_work_pulses", n_work, 1);
        check("p1_ack_pulses", n_ack, 1);
        check("p1_frame_cnt", frame_cnt, 1);
        ones_din = 0; fix_lat = 0;

        // both requesters held high from reset: grants alternate 0,1,0,1
        do_reset();
        n_ack = 0; left = '{2, 2};
        run_until_cnt("p2_done", 4, 800);
        check("p2_grant_order", hist[3:0], 4'b0101);
        check("p2_ack_pulses", n_ack, 4);

        // decoder busy after grant: dec_work deferred until dec_free rises
        stall_on_grant = 1; left = '{1, 0};
        run_until_cnt("p3_done", 5, 300);
        stall_on_grant = 0;

        // downstream back-pressure for 50 cycles while requester 1 waits
        hold_ready = 1; fix_lat = 10; left = '{1, 1}; gap = '{0, 45};
        run_until_cnt("p4_done", 7, 400);
        hold_ready = 0; fix_lat = 0;

        // randomized traffic
        gap_max = 6; rnd_ready = 1; rnd_stall = 1; left = '{20, 20};
        for (int k = 0; k < 20000 && (left[0] > 0 || left[1] > 0 || inflight); k++) cycle();
        check("rnd_done", left[0] == 0 && left[1] == 0 && !inflight, 1);
        check("rnd_frame_cnt", frame_cnt, 47);
        gap_max = 0; rnd_ready = 0; rnd_stall = 0;

`ifdef LDPC_SCHED_TIMEOUT_EN
        // silent decoder: watchdog returns the raw frame, late valid ignored
        fix_lat = 40; left = '{0, 1};
        run_until_cnt("to_done", cnt + CW'(1), 300);
        repeat (40) cycle();
        fix_lat = 0;
`endif

        // reset while waiting on the decoder drops the frame
        fix_lat = 60; left = '{1, 0};
        for (int k = 0; k < 200 && !(win && w >= 3); k++) cycle();
        check("mid_wait_reached", win && w >= 3, 1);
        do_reset();
        repeat (30) cycle();
        check("post_rst_frame_cnt", frame_cnt, 0);
        check("post_rst_res_valid", dif.res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
